fifo_burst_reader: RTL and testbench

Read-side master for the team's synchronous FIFO. On a `start` pulse it drains exactly `burst_len` words from the FIFO, accounting for the FIFO's one-cycle registered read latency. It re-presents the words on a valid/ready stream with `m_last` on the final word, then pulses `done`. It sits between a FIFO instance and any downstream stream consumer (DMA, serializer, packetizer).

---
 rtl/fifo_burst_reader_if.sv | 29 ++
 rtl/fifo_burst_reader.sv | 138 +++++++++++++
 tb/tb_fifo_burst_reader.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_if.sv
// Signal bundle for fifo_burst_reader: start/status, FIFO read port and output stream.
// The reader side uses the master modport; the environment (FIFO + consumer) uses slave.
interface fifo_burst_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
);
    logic                  start;
    logic [LEN_WIDTH-1:0]  burst_len;
    logic                  busy;
    logic                  done;
    logic                  fifo_cs;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_last;
    logic                  m_ready;

    modport master (
        input  start, burst_len, fifo_data, fifo_empty, m_ready,
        output busy, done, fifo_cs, fifo_rd_en, m_data, m_valid, m_last
    );

    modport slave (
        output start, burst_len, fifo_data, fifo_empty, m_ready,
        input  busy, done, fifo_cs, fifo_rd_en, m_data, m_valid, m_last
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Burst reader: pops burst_len words from a registered-output FIFO and replays them
// on a valid/ready stream through a 3-entry skid buffer, flagging the last word.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    fifo_burst_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    logic                  busy_q;
    logic                  done_q;
    logic                  cs_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issued;
    logic [LEN_WIDTH-1:0]  sent;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] buf_mem [3];
    logic [1:0]            buf_cnt;
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [2:0]            occupancy;
    logic                  start_acc;
    logic                  rd_en;
    logic                  m_valid;
    logic                  hs;
    logic                  is_last;

    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign start_acc = (state == IDLE) && bus.start;

    // Words buffered plus the one still in the FIFO's output register; capping this
    // at 3 guarantees a slot for every pop without looking at m_ready.
    assign occupancy = {1'b0, buf_cnt} + {2'b00, inflight};
    assign rd_en     = (state == RUN) && !bus.fifo_empty && (issued < len_q) && (occupancy < 3'd3);

    assign m_valid = (buf_cnt != 2'd0);
    assign hs      = m_valid && bus.m_ready;
    assign is_last = m_valid && (sent == len_q - LEN_WIDTH'(1));

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = m_valid;
    assign bus.m_last     = is_last;
    assign bus.m_data     = m_valid ? buf_mem[rd_ptr] : '0;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.fifo_cs    = cs_q;

    // NOTE: state registers use non-blocking assignments so every always_ff samples
    // the pre-edge values of its neighbours, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cs_q   <= 1'b0;
            len_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        len_q  <= bus.burst_len;
                        busy_q <= 1'b1;
                        if (bus.burst_len == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= RUN;
                            cs_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (hs && is_last) begin
                        state  <= DONE;
                        cs_q   <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    cs_q   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued   <= '0;
            sent     <= '0;
            inflight <= 1'b0;
        end else begin
            if (start_acc) begin
                issued <= '0;
                sent   <= '0;
            end else begin
                if (rd_en) issued <= issued + LEN_WIDTH'(1);
                if (hs)    sent   <= sent + LEN_WIDTH'(1);
            end
            inflight <= rd_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_cnt <= 2'd0;
            wr_ptr  <= 2'd0;
            rd_ptr  <= 2'd0;
        end else begin
            if (inflight) wr_ptr <= next_ptr(wr_ptr);
            if (hs)       rd_ptr <= next_ptr(rd_ptr);
            unique case ({inflight, hs})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    // NOTE: the data storage has no reset; buf_cnt gates validity and m_data is
    // forced to zero while empty, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (inflight) buf_mem[wr_ptr] <= bus.fifo_data;
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural registered-output FIFO,
// a stream monitor, a table of burst vectors and hand-written corner sequences.
module tb_fifo_burst_reader;
    localparam int DW = 32;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_burst_reader_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural FIFO with one-cycle registered read data.
    logic [DW-1:0] fmem [16];
    logic [DW-1:0] fdata   = '0;
    logic [DW-1:0] f_wdata = '0;
    logic          f_wr    = 1'b0;
    logic          f_clr   = 1'b0;
    logic          fpop;
    int            fcount  = 0;
    int            frd     = 0;
    int            fwr     = 0;

    assign bus.fifo_empty = (fcount == 0);
    assign bus.fifo_data  = fdata;
    assign fpop           = bus.fifo_rd_en && !bus.fifo_empty;

    always @(posedge clk) begin
        if (f_clr) begin
            fcount <= 0;
            frd    <= 0;
            fwr    <= 0;
        end else begin
            if (fpop) begin
                fdata <= fmem[frd];
                frd   <= (frd + 1) % 16;
            end
            if (f_wr) begin
                fmem[fwr] <= f_wdata;
                fwr       <= (fwr + 1) % 16;
            end
            fcount <= fcount + (f_wr ? 1 : 0) - (fpop ? 1 : 0);
        end
    end

    // Stream monitor and event counters.
    logic [DW-1:0] got_data [$];
    logic          got_last [$];
    int            done_cnt   = 0;
    int            pop_cnt    = 0;
    int            bad_rd     = 0;
    int            unstable   = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;

    always @(posedge clk) begin
        if (bus.m_valid && bus.m_ready) begin
            got_data.push_back(bus.m_data);
            got_last.push_back(bus.m_last);
        end
        if (bus.done) done_cnt++;
        if (fpop) pop_cnt++;
        if (bus.fifo_rd_en && bus.fifo_empty) bad_rd++;
        if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data || bus.m_last !== prev_last))
            unstable++;
        prev_stall = rst_n && bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
        prev_last  = bus.m_last;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fifo_flush();
        f_clr = 1'b1;
        @(negedge clk);
        f_clr = 1'b0;
    endtask

    task automatic preload(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            f_wr    = 1'b1;
            f_wdata = base + DW'(i);
            @(negedge clk);
        end
        f_wr = 1'b0;
    endtask

    task automatic pulse_start(input logic [LW-1:0] len);
        bus.start     = 1'b1;
        bus.burst_len = len;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.burst_len = '0;
    endtask

    task automatic wait_done(input int max, input bit toggle, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max && !ok; c++) begin
            bus.m_ready = toggle ? c[0] : 1'b1;
            @(negedge clk);
            if (bus.done) ok = 1'b1;
        end
        bus.m_ready = 1'b1;
    endtask

    task automatic check_stream(input string name, input int start_idx, input logic [DW-1:0] base, input int n);
        check({name, " count"}, 32'(got_data.size() - start_idx), 32'(n));
        for (int i = 0; i < n && start_idx + i < got_data.size(); i++) begin
            check($sformatf("%s word%0d", name, i), got_data[start_idx + i], base + DW'(i));
            check($sformatf("%s last%0d", name, i), 32'(got_last[start_idx + i]), 32'(i == n - 1));
        end
    endtask

    function automatic logic [31:0] ctrl_outs();
        return {26'd0, bus.busy, bus.done, bus.fifo_cs, bus.fifo_rd_en, bus.m_valid, bus.m_last};
    endfunction

    typedef struct {
        logic [DW-1:0] base;
        int            n_pre;
        logic [LW-1:0] len;
        bit            toggle;
        int            exp_pops;
        int            exp_left;
    } burst_vec_t;

    burst_vec_t  vecs [4];
    logic [13:0] timing_exp [8];
    int          d0, p0, dn0, b0, u0, busy_low;
    bit          ok;
    logic [7:0]  act_data;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{base: 32'h11, n_pre: 4,  len: 8'd4,  toggle: 1'b0, exp_pops: 4,  exp_left: 0};
        vecs[1] = '{base: 32'h21, n_pre: 6,  len: 8'd3,  toggle: 1'b1, exp_pops: 3,  exp_left: 3};
        vecs[2] = '{base: 32'hA0, n_pre: 10, len: 8'd10, toggle: 1'b0, exp_pops: 10, exp_left: 0};
        vecs[3] = '{base: 32'h50, n_pre: 2,  len: 8'd1,  toggle: 1'b1, exp_pops: 1,  exp_left: 1};
        // {busy, fifo_cs, rd_en, m_valid, m_last, done, m_data[7:0]} per cycle after start
        timing_exp[0] = {6'b111000, 8'h00};
        timing_exp[1] = {6'b111000, 8'h00};
        timing_exp[2] = {6'b111100, 8'h11};
        timing_exp[3] = {6'b111100, 8'h12};
        timing_exp[4] = {6'b110100, 8'h13};
        timing_exp[5] = {6'b110110, 8'h14};
        timing_exp[6] = {6'b100001, 8'h00};
        timing_exp[7] = {6'b000000, 8'h00};

        rst_n         = 1'b1;
        bus.start     = 1'b0;
        bus.burst_len = '0;
        bus.m_ready   = 1'b0;
        #2 rst_n = 1'b0;
        f_clr = 1'b1;
        tick(2);
        check("reset ctrl outputs", ctrl_outs(), 32'd0);
        check("reset m_data", bus.m_data, 32'd0);
        f_clr = 1'b0;
        rst_n = 1'b1;
        tick(2);
        check("post-reset ctrl outputs", ctrl_outs(), 32'd0);

        // Cycle-exact basic burst: 2-cycle first-word latency, back-to-back words.
        preload(32'h11, 4);
        bus.m_ready = 1'b1;
        pulse_start(8'd4);
        for (int i = 0; i < 8; i++) begin
            act_data = timing_exp[i][10] ? bus.m_data[7:0] : 8'h00;
            check($sformatf("timing cycle%0d", i),
                  32'({bus.busy, bus.fifo_cs, bus.fifo_rd_en, bus.m_valid, bus.m_last, bus.done, act_data}),
                  32'(timing_exp[i]));
            tick(1);
        end

        // Table of bursts with varying length, preload and consumer pattern.
        for (int v = 0; v < 4; v++) begin
            fifo_flush();
            preload(vecs[v].base, vecs[v].n_pre);
            d0  = got_data.size();
            p0  = pop_cnt;
            dn0 = done_cnt;
            b0  = bad_rd;
            bus.m_ready = !vecs[v].toggle;
            pulse_start(vecs[v].len);
            wait_done(300, vecs[v].toggle, ok);
            check($sformatf("vec%0d done seen", v), 32'(ok), 32'd1);
            tick(1);
            check_stream($sformatf("vec%0d", v), d0, vecs[v].base, int'(vecs[v].len));
            check($sformatf("vec%0d pops", v), 32'(pop_cnt - p0), 32'(vecs[v].exp_pops));
            check($sformatf("vec%0d fifo left", v), 32'(fcount), 32'(vecs[v].exp_left));
            check($sformatf("vec%0d done pulses", v), 32'(done_cnt - dn0), 32'd1);
            check($sformatf("vec%0d rd_en while empty", v), 32'(bad_rd - b0), 32'd0);
            check($sformatf("vec%0d idle after", v), ctrl_outs(), 32'd0);
        end

        // Empty stall: burst of 5 fed in two installments.
        fifo_flush();
        bus.m_ready = 1'b1;
        d0 = got_data.size();
        b0 = bad_rd;
        busy_low = 0;
        pulse_start(8'd5);
        for (int i = 0; i < 3; i++) begin
            if (!bus.busy) busy_low++;
            tick(1);
        end
        preload(32'h31, 2);
        for (int i = 0; i < 10; i++) begin
            if (!bus.busy) busy_low++;
            tick(1);
        end
        check("stall m_valid drained", 32'(bus.m_valid), 32'd0);
        check("stall partial words", 32'(got_data.size() - d0), 32'd2);
        preload(32'h33, 3);
        wait_done(100, 1'b0, ok);
        check("stall done seen", 32'(ok), 32'd1);
        tick(1);
        check_stream("stall", d0, 32'h31, 5);
        check("stall busy held", 32'(busy_low), 32'd0);
        check("stall rd_en while empty", 32'(bad_rd - b0), 32'd0);

        // Backpressure: consumer stalled for 10 cycles with a full FIFO.
        fifo_flush();
        preload(32'h40, 8);
        bus.m_ready = 1'b0;
        d0 = got_data.size();
        p0 = pop_cnt;
        u0 = unstable;
        pulse_start(8'd8);
        tick(10);
        check("bp pops while stalled", 32'(pop_cnt - p0), 32'd3);
        check("bp m_valid held", 32'(bus.m_valid), 32'd1);
        check("bp m_data head", bus.m_data, 32'h40);
        check("bp m_last low", 32'(bus.m_last), 32'd0);
        wait_done(100, 1'b0, ok);
        check("bp done seen", 32'(ok), 32'd1);
        tick(1);
        check_stream("bp", d0, 32'h40, 8);
        check("bp data stable while stalled", 32'(unstable - u0), 32'd0);
        check("bp total pops", 32'(pop_cnt - p0), 32'd8);
        check("bp fifo left", 32'(fcount), 32'd0);

        // Zero-length burst.
        fifo_flush();
        preload(32'h99, 1);
        d0 = got_data.size();
        p0 = pop_cnt;
        pulse_start(8'd0);
        check("zero done/busy", ctrl_outs(), 32'b110000);
        tick(1);
        check("zero back to idle", ctrl_outs(), 32'd0);
        check("zero pops", 32'(pop_cnt - p0), 32'd0);
        check("zero words", 32'(got_data.size() - d0), 32'd0);

        // Start during RUN is ignored.
        fifo_flush();
        preload(32'h60, 5);
        bus.m_ready = 1'b1;
        d0  = got_data.size();
        p0  = pop_cnt;
        dn0 = done_cnt;
        pulse_start(8'd3);
        pulse_start(8'd7);
        wait_done(100, 1'b0, ok);
        check("ign done seen", 32'(ok), 32'd1);
        tick(4);
        check_stream("ign", d0, 32'h60, 3);
        check("ign pops", 32'(pop_cnt - p0), 32'd3);
        check("ign fifo left", 32'(fcount), 32'd2);
        check("ign done pulses", 32'(done_cnt - dn0), 32'd1);
        check("ign idle", ctrl_outs(), 32'd0);

        // Reset in the middle of a 6-word burst, then a fresh 2-word burst.
        fifo_flush();
        preload(32'h70, 6);
        bus.m_ready = 1'b1;
        d0 = got_data.size();
        pulse_start(8'd6);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (got_data.size() - d0 >= 2) ok = 1'b1;
            else tick(1);
        end
        check("rst reached 2 words", 32'(ok), 32'd1);
        check("rst burst still active", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst immediate ctrl", ctrl_outs(), 32'd0);
        check("rst immediate m_data", bus.m_data, 32'd0);
        f_clr = 1'b1;
        tick(2);
        check("rst held ctrl", ctrl_outs(), 32'd0);
        f_clr = 1'b0;
        rst_n = 1'b1;
        tick(1);
        preload(32'h80, 2);
        d0  = got_data.size();
        dn0 = done_cnt;
        pulse_start(8'd2);
        wait_done(100, 1'b0, ok);
        check("post-rst done seen", 32'(ok), 32'd1);
        tick(1);
        check_stream("post-rst", d0, 32'h80, 2);
        check("post-rst done pulses", 32'(done_cnt - dn0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
